plic_core: RTL and testbench

PLIC_CORE -- requirements
Module: plic_core

---
 rtl/plic_core.sv | 189 ++++++++++++++++++
 tb/tb_plic_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_core.sv
`default_nettype none
// ============================================================================
//  Module   : plic_core
//  Purpose  : Platform-level interrupt controller core with level/edge gateways
//             and per-target registered arbitration.
//  Revision : 1.0
// ============================================================================
module plic_core #(
    parameter int N_SOURCE   = 64,
    parameter int N_TARGET   = 2,
    parameter int MAX_PRIO   = 7,
    parameter int EDGE_CNT_W = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                reg_valid_i,
    input  logic                reg_write_i,
    input  logic [25:0]         reg_addr_i,
    input  logic [31:0]         reg_wdata_i,
    output logic                reg_ready_o,
    output logic [31:0]         reg_rdata_o,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] irq_sources_i,
    output logic [N_TARGET-1:0] eip_targets_o
);
    localparam int PRIOW = $clog2(MAX_PRIO + 1);
    localparam int IDW   = $clog2(N_SOURCE + 1);
    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

    logic [PRIOW-1:0]      prio_q [1:N_SOURCE];
    logic [PRIOW-1:0]      prio_d [1:N_SOURCE];
    logic [N_SOURCE:1]     ie_q [N_TARGET];
    logic [N_SOURCE:1]     ie_d [N_TARGET];
    logic [PRIOW-1:0]      thr_q [N_TARGET];
    logic [PRIOW-1:0]      thr_d [N_TARGET];
    logic [EDGE_CNT_W-1:0] cnt_q [1:N_SOURCE];
    logic [EDGE_CNT_W-1:0] cnt_d [1:N_SOURCE];
    logic [IDW-1:0]        winner_q [N_TARGET];
    logic [IDW-1:0]        winner_d [N_TARGET];
    logic [N_SOURCE:1]     inflight_q, inflight_d, ipl_q, ipl_d;
    logic [N_SOURCE-1:0]   irq_q, rise_w;
    logic [N_TARGET-1:0]   eip_q, eip_d;
    logic                  ready_q;
    logic [31:0]           rdata_q, rdata_d;

    logic [25:0]           addr_w;
    logic                  prio_sel, pend_sel, en_sel, thr_sel, clm_sel;
    int                    prio_id, en_t, ctx_t, word_idx;
    logic [IDW-1:0]        claim_id;
    logic [N_SOURCE:1]     done_vec, claim_vec, ip_w, cand_w;
    logic [IDW-1:0]        best_id;
    logic [PRIOW-1:0]      best_p;

    assign addr_w   = {reg_addr_i[25:2], 2'b00};
    assign prio_id  = int'(addr_w[11:2]);
    assign word_idx = int'(addr_w[6:2]);
    assign en_t     = int'(addr_w[25:7]) - 64;
    assign ctx_t    = int'(addr_w[25:12]) - 512;
    assign prio_sel = (addr_w[25:12] == 14'd0) && (prio_id >= 1) && (prio_id <= N_SOURCE);
    assign pend_sel = (addr_w[25:7] == 19'h00020);
    assign en_sel   = (addr_w >= 26'h0002000) && (addr_w < 26'h0200000) && (en_t < N_TARGET);
    assign thr_sel  = (addr_w >= 26'h0200000) && (ctx_t < N_TARGET) && (addr_w[11:0] == 12'h000);
    assign clm_sel  = (addr_w >= 26'h0200000) && (ctx_t < N_TARGET) && (addr_w[11:0] == 12'h004);
    assign rise_w   = irq_sources_i & ~irq_q;

    // Gather the 32 IDs of word w; ID 0 and IDs beyond N_SOURCE read as zero.
    function automatic logic [31:0] pack_word(input logic [N_SOURCE:1] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if ((32 * w + b) >= 1 && (32 * w + b) <= N_SOURCE) r[b] = v[32 * w + b];
        end
        return r;
    endfunction

    always_comb begin
        prio_d   = prio_q;
        ie_d     = ie_q;
        thr_d    = thr_q;
        rdata_d  = '0;
        claim_id = '0;
        done_vec = '0;
        if (reg_valid_i && reg_write_i) begin
            if (prio_sel) prio_d[prio_id] = reg_wdata_i[PRIOW-1:0];
            if (en_sel) begin
                for (int b = 0; b < 32; b++) begin
                    if ((32 * word_idx + b) >= 1 && (32 * word_idx + b) <= N_SOURCE)
                        ie_d[en_t][32 * word_idx + b] = reg_wdata_i[b];
                end
            end
            if (thr_sel) thr_d[ctx_t] = reg_wdata_i[PRIOW-1:0];
            if (clm_sel && reg_wdata_i != 32'd0 && reg_wdata_i <= 32'(N_SOURCE)) begin
                if (inflight_q[int'(reg_wdata_i)] && ie_q[ctx_t][int'(reg_wdata_i)])
                    done_vec[int'(reg_wdata_i)] = 1'b1;
            end
        end else if (reg_valid_i) begin
            if (prio_sel) rdata_d = 32'(prio_q[prio_id]);
            if (pend_sel) rdata_d = pack_word(ip_w, word_idx);
            if (en_sel)   rdata_d = pack_word(ie_q[en_t], word_idx);
            if (thr_sel)  rdata_d = 32'(thr_q[ctx_t]);
            if (clm_sel && eip_q[ctx_t]) begin
                rdata_d  = 32'(winner_q[ctx_t]);
                claim_id = winner_q[ctx_t];
            end
        end
    end

    // Gateways: a claim beats a same-cycle edge, leaving the edge counter unchanged.
    always_comb begin
        inflight_d = inflight_q;
        ipl_d      = ipl_q;
        cnt_d      = cnt_q;
        claim_vec  = '0;
        ip_w       = '0;
        cand_w     = '0;
        for (int id = 1; id <= N_SOURCE; id++) begin
            claim_vec[id]  = (claim_id == IDW'(id));
            inflight_d[id] = (inflight_q[id] & ~done_vec[id]) | claim_vec[id];
            if (claim_vec[id])
                ipl_d[id] = 1'b0;
            else if (irq_sources_i[id-1] && !inflight_q[id])
                ipl_d[id] = 1'b1;
            if (le_i[id-1]) begin
                if (rise_w[id-1] && !claim_vec[id] && cnt_q[id] != CNT_MAX)
                    cnt_d[id] = cnt_q[id] + EDGE_CNT_W'(1);
                else if (claim_vec[id] && !rise_w[id-1] && cnt_q[id] != '0)
                    cnt_d[id] = cnt_q[id] - EDGE_CNT_W'(1);
            end
            ip_w[id]   = le_i[id-1] ? ((cnt_q[id] != '0) && !inflight_q[id]) : ipl_q[id];
            // The source claimed this cycle must not win again on the next access.
            cand_w[id] = ip_w[id] && !claim_vec[id] && (prio_q[id] != '0);
        end
    end

    always_comb begin
        best_id = '0;
        best_p  = '0;
        for (int t = 0; t < N_TARGET; t++) begin
            best_id = '0;
            best_p  = '0;
            for (int id = 1; id <= N_SOURCE; id++) begin
                if (cand_w[id] && ie_q[t][id] && prio_q[id] > best_p) begin
                    best_p  = prio_q[id];
                    best_id = IDW'(id);
                end
            end
            winner_d[t] = best_id;
            eip_d[t]    = (best_id != '0) && (best_p > thr_q[t]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int id = 1; id <= N_SOURCE; id++) begin
                prio_q[id] <= '0;
                cnt_q[id]  <= '0;
            end
            for (int t = 0; t < N_TARGET; t++) begin
                ie_q[t]     <= '0;
                thr_q[t]    <= '0;
                winner_q[t] <= '0;
            end
            inflight_q <= '0;
            ipl_q      <= '0;
            irq_q      <= '0;
            eip_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            ie_q       <= ie_d;
            thr_q      <= thr_d;
            winner_q   <= winner_d;
            inflight_q <= inflight_d;
            ipl_q      <= ipl_d;
            irq_q      <= irq_sources_i;
            eip_q      <= eip_d;
            ready_q    <= reg_valid_i;
            rdata_q    <= rdata_d;
        end
    end

    assign reg_ready_o   = ready_q;
    assign reg_rdata_o   = rdata_q;
    assign eip_targets_o = eip_q;

endmodule
`default_nettype wire

// File: tb/tb_plic_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plic_core
//  Purpose  : Directed self-checking bench for plic_core (64 sources, 2 targets).
//  Revision : 1.0
// ============================================================================
module tb_plic_core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        write = 1'b0;
    logic [25:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        ready;
    logic [31:0] rdata;
    logic [63:0] le = 64'h0000_0080_0000_0840;
    logic [63:0] irq = '0;
    logic [1:0]  eip;
    int          total = 0;
    int          bad = 0;
    logic [31:0] r;
    logic        rdy;

    always #5 clk = ~clk;

    plic_core dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .reg_valid_i   (valid),
        .reg_write_i   (write),
        .reg_addr_i    (addr),
        .reg_wdata_i   (wdata),
        .reg_ready_o   (ready),
        .reg_rdata_o   (rdata),
        .le_i          (le),
        .irq_sources_i (irq),
        .eip_targets_o (eip)
    );

    task automatic acc(input logic w, input logic [25:0] a, input logic [31:0] d,
                       output logic [31:0] rd_o, output logic rdy_o);
        @(negedge clk);
        valid = 1'b1; write = w; addr = a; wdata = d;
        @(posedge clk); #1;
        rd_o = rdata; rdy_o = ready;
        valid = 1'b0; write = 1'b0;
    endtask

    task automatic wr(input logic [25:0] a, input logic [31:0] d);
        logic [31:0] dummy; logic dr;
        acc(1'b1, a, d, dummy, dr);
    endtask

    task automatic rd(input logic [25:0] a, output logic [31:0] d);
        logic dr;
        acc(1'b0, a, 32'd0, d, dr);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int id);
        @(negedge clk); irq[id-1] = 1'b1;
        @(negedge clk); irq[id-1] = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        total++; if (eip !== 2'b00) begin bad++; $display("FAIL rst_eip got=%b want=00", eip); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        @(negedge clk); rst_n = 1'b1;
        acc(1'b0, 26'h14, 32'd0, r, rdy);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rst_prio5 got=%h want=0", r); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rst_ready_pulse got=%b want=1", rdy); end
        rd(26'h200004, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rst_claim got=%h want=0", r); end
    endtask

    task automatic test_regs;
        wr(26'h0, 32'd7); rd(26'h0, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL prio0 got=%h want=0", r); end
        wr(26'h28, 32'hFF); rd(26'h28, r);
        total++; if (r !== 32'd7) begin bad++; $display("FAIL prio_mask got=%h want=7", r); end
        wr(26'h1000, 32'hFFFF_FFFF); rd(26'h1000, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL pend_write got=%h want=0", r); end
        wr(26'h2100, 32'hFFFF_FFFF); rd(26'h2100, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL en_bad_target got=%h want=0", r); end
        rd(26'h100000, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL reserved got=%h want=0", r); end
        wr(26'h2080, 32'hFFFF_FFFF); rd(26'h2080, r);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL en_word0 got=%h want=fffffffe", r); end
        wr(26'h2084, 32'hFFFF_FFFF); rd(26'h2084, r);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL en_word1 got=%h want=ffffffff", r); end
        wr(26'h2088, 32'hFFFF_FFFF); rd(26'h2088, r);
        total++; if (r !== 32'h0000_0001) begin bad++; $display("FAIL en_word2 got=%h want=1", r); end
        wr(26'h2080, 32'd0); wr(26'h2084, 32'd0); wr(26'h2088, 32'd0);
        wr(26'h201000, 32'hD); rd(26'h201000, r);
        total++; if (r !== 32'd5) begin bad++; $display("FAIL thr_mask got=%h want=5", r); end
        wr(26'h201000, 32'd0);
    endtask

    task automatic test_back_to_back;
        @(negedge clk); valid = 1'b1; write = 1'b1; addr = 26'h28; wdata = 32'd3;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready got=%b want=1", ready); end
        @(negedge clk); write = 1'b0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b1 || rdata !== 32'd3) begin bad++; $display("FAIL b2b_rd got=%b/%h want=1/3", ready, rdata); end
        @(negedge clk); valid = 1'b0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0 || rdata !== 32'd0) begin bad++; $display("FAIL b2b_idle got=%b/%h want=0/0", ready, rdata); end
        wr(26'h28, 32'd0);
    endtask

    task automatic test_level;
        int k;
        wr(26'h14, 32'd3); wr(26'h2000, 32'h20); wr(26'h200000, 32'd0);
        @(negedge clk); irq[4] = 1'b1;
        k = 0;
        while (eip[0] !== 1'b1 && k < 3) begin @(posedge clk); #1; k++; end
        total++; if (eip[0] !== 1'b1) begin bad++; $display("FAIL level_eip got=%b want=1", eip[0]); end
        rd(26'h200004, r);
        total++; if (r !== 32'd5) begin bad++; $display("FAIL level_claim got=%0d want=5", r); end
        idle(1);
        total++; if (eip[0] !== 1'b0) begin bad++; $display("FAIL level_eip_after got=%b want=0", eip[0]); end
        rd(26'h1000, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL level_pend_inflight got=%h want=0", r); end
        wr(26'h200004, 32'd5);
        k = 0;
        while (eip[0] !== 1'b1 && k < 4) begin @(posedge clk); #1; k++; end
        total++; if (eip[0] !== 1'b1) begin bad++; $display("FAIL level_repend_eip got=%b want=1", eip[0]); end
        rd(26'h1000, r);
        total++; if (r !== 32'h20) begin bad++; $display("FAIL level_repend got=%h want=20", r); end
        rd(26'h200004, r);
        total++; if (r !== 32'd5) begin bad++; $display("FAIL level_claim2 got=%0d want=5", r); end
        @(negedge clk); irq[4] = 1'b0;
        wr(26'h200004, 32'd5); wr(26'h14, 32'd0);
        idle(2);
        total++; if (eip[0] !== 1'b0) begin bad++; $display("FAIL level_done got=%b want=0", eip[0]); end
    endtask

    task automatic test_edge;
        wr(26'hA0, 32'd1); wr(26'h2004, 32'h100);
        pulse(40); pulse(40); pulse(40);
        idle(2);
        rd(26'h1004, r);
        total++; if (r !== 32'h100) begin bad++; $display("FAIL edge_pend got=%h want=100", r); end
        for (int i = 0; i < 3; i++) begin
            rd(26'h200004, r);
            total++; if (r !== 32'd40) begin bad++; $display("FAIL edge_claim%0d got=%0d want=40", i, r); end
            wr(26'h200004, 32'd40);
            idle(2);
        end
        rd(26'h200004, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL edge_claim4 got=%0d want=0", r); end
        wr(26'hA0, 32'd0); wr(26'h2004, 32'd0);
    endtask

    task automatic test_tie;
        wr(26'h8, 32'd4); wr(26'h24, 32'd4); wr(26'h2080, 32'h204);
        @(negedge clk); irq[1] = 1'b1; irq[8] = 1'b1;
        idle(3);
        total++; if (eip[1] !== 1'b1) begin bad++; $display("FAIL tie_eip got=%b want=1", eip[1]); end
        rd(26'h201004, r);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL tie_claim got=%0d want=2", r); end
        wr(26'h201004, 32'd2); wr(26'h24, 32'd5);
        idle(3);
        rd(26'h201004, r);
        total++; if (r !== 32'd9) begin bad++; $display("FAIL tie_prio_claim got=%0d want=9", r); end
        idle(2);
        rd(26'h201004, r);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL tie_next_claim got=%0d want=2", r); end
        @(negedge clk); irq[1] = 1'b0; irq[8] = 1'b0;
        wr(26'h201004, 32'd9); wr(26'h201004, 32'd2);
        wr(26'h8, 32'd0); wr(26'h24, 32'd0); wr(26'h2080, 32'd0);
    endtask

    task automatic test_threshold;
        wr(26'hC, 32'd2); wr(26'h2000, 32'h8); wr(26'h200000, 32'd2);
        @(negedge clk); irq[2] = 1'b1;
        idle(3);
        total++; if (eip[0] !== 1'b0) begin bad++; $display("FAIL thr_eip_masked got=%b want=0", eip[0]); end
        rd(26'h200004, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL thr_claim0 got=%0d want=0", r); end
        wr(26'h200000, 32'd1);
        idle(2);
        total++; if (eip[0] !== 1'b1) begin bad++; $display("FAIL thr_eip got=%b want=1", eip[0]); end
        rd(26'h200004, r);
        total++; if (r !== 32'd3) begin bad++; $display("FAIL thr_claim got=%0d want=3", r); end
        @(negedge clk); irq[2] = 1'b0;
        wr(26'h200004, 32'd3); wr(26'hC, 32'd0); wr(26'h200000, 32'd0);
    endtask

    task automatic test_complete;
        wr(26'h1C, 32'd1); wr(26'h2000, 32'h80);
        pulse(7);
        idle(2);
        wr(26'h200004, 32'd7);
        idle(1);
        rd(26'h1000, r);
        total++; if (r !== 32'h80) begin bad++; $display("FAIL cmp_not_inflight got=%h want=80", r); end
        rd(26'h200004, r);
        total++; if (r !== 32'd7) begin bad++; $display("FAIL cmp_claim got=%0d want=7", r); end
        wr(26'h201004, 32'd7);
        pulse(7);
        idle(2);
        rd(26'h1000, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL cmp_not_enabled got=%h want=0", r); end
        wr(26'h200004, 32'd7);
        idle(1);
        rd(26'h1000, r);
        total++; if (r !== 32'h80) begin bad++; $display("FAIL cmp_done got=%h want=80", r); end
        idle(1);
        @(negedge clk); valid = 1'b1; write = 1'b0; addr = 26'h200004; irq[6] = 1'b1;
        @(posedge clk); #1;
        r = rdata; valid = 1'b0;
        total++; if (r !== 32'd7) begin bad++; $display("FAIL cmp_edge_claim got=%0d want=7", r); end
        @(negedge clk); irq[6] = 1'b0;
        wr(26'h200004, 32'd7);
        idle(1);
        rd(26'h1000, r);
        total++; if (r !== 32'h80) begin bad++; $display("FAIL cmp_cnt_kept got=%h want=80", r); end
        idle(1);
        rd(26'h200004, r);
        total++; if (r !== 32'd7) begin bad++; $display("FAIL cmp_claim_last got=%0d want=7", r); end
        wr(26'h200004, 32'd7);
        idle(1);
        rd(26'h1000, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL cmp_drained got=%h want=0", r); end
        wr(26'h1C, 32'd0);
    endtask

    task automatic test_reset_edge;
        wr(26'h30, 32'd1); wr(26'h2000, 32'h1000);
        pulse(12); pulse(12);
        idle(2);
        total++; if (eip[0] !== 1'b1) begin bad++; $display("FAIL rste_eip got=%b want=1", eip[0]); end
        @(negedge clk); valid = 1'b1; write = 1'b0; addr = 26'h200004;
        #2 rst_n = 1'b0;
        #1;
        total++; if (eip !== 2'b00 || ready !== 1'b0 || rdata !== 32'd0)
            begin bad++; $display("FAIL rste_during got=%b/%b/%h want=00/0/0", eip, ready, rdata); end
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rste_held_ready got=%b want=0", ready); end
        @(negedge clk); valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rste_no_pulse got=%b want=0", ready); end
        rd(26'h1000, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rste_pend got=%h want=0", r); end
        rd(26'h30, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rste_prio got=%h want=0", r); end
        rd(26'h2000, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL rste_en got=%h want=0", r); end
        idle(2);
        total++; if (eip !== 2'b00) begin bad++; $display("FAIL rste_eip_after got=%b want=00", eip); end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_back_to_back;
        test_level;
        test_edge;
        test_tie;
        test_threshold;
        test_complete;
        test_reset_edge;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
